// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator for the 5-port router.
// Each output (R, L, U, D, EJ) independently picks one requesting input,
// holds it for the whole packet (wormhole lock) and releases it after the
// tail flit pops. Select codes are registered; pops are combinational.
// Port code: 0=R, 1=L, 2=U, 3=D, 4=EJ, 7=idle; 5 and 6 are illegal.
//
// Handshake: an input flit transfers in a cycle exactly when pop_i=1, i.e.
// the input presents req_i, its destination output is locked to it, and that
// output asserts rdy. The upstream buffer advances on pop_i; req/dst/tail may
// change only after a cycle in which pop_i=1 (or while no lock is held).
module switch_allocator #(
    parameter logic [2:0] IDLE_CODE = 3'b111,
    parameter logic [2:0] RR_INIT   = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       R_req,
    input  logic       L_req,
    input  logic       U_req,
    input  logic       D_req,
    input  logic       EJ_req,
    input  logic [2:0] R_dst,
    input  logic [2:0] L_dst,
    input  logic [2:0] U_dst,
    input  logic [2:0] D_dst,
    input  logic [2:0] EJ_dst,
    input  logic       R_tail,
    input  logic       L_tail,
    input  logic       U_tail,
    input  logic       D_tail,
    input  logic       EJ_tail,
    input  logic       R_rdy,
    input  logic       L_rdy,
    input  logic       U_rdy,
    input  logic       D_rdy,
    input  logic       EJ_rdy,
    output logic [2:0] Ri,
    output logic [2:0] Le,
    output logic [2:0] Up,
    output logic [2:0] Do,
    output logic [2:0] Ej,
    output logic       R_pop,
    output logic       L_pop,
    output logic       U_pop,
    output logic       D_pop,
    output logic       EJ_pop,
    output logic       err_dst
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    logic [4:0] req;
    logic [4:0] tail;
    logic [4:0] rdy;
    logic [4:0] pop;
    logic [4:0] rel;
    logic [4:0] bad_dst;
    logic [2:0] dst [5];

    state_t     state_q [5];
    state_t     state_d [5];
    logic [2:0] sel_q   [5];
    logic [2:0] sel_d   [5];
    logic [2:0] ptr_q   [5];
    logic [2:0] ptr_d   [5];
    logic       err_q;

    logic       found;
    logic [2:0] idx;
    logic [2:0] win;

    assign req  = {EJ_req, D_req, U_req, L_req, R_req};
    assign tail = {EJ_tail, D_tail, U_tail, L_tail, R_tail};
    assign rdy  = {EJ_rdy, D_rdy, U_rdy, L_rdy, R_rdy};
    assign dst[0] = R_dst;
    assign dst[1] = L_dst;
    assign dst[2] = U_dst;
    assign dst[3] = D_dst;
    assign dst[4] = EJ_dst;

    // Round-robin successor, wrapping 4 -> 0.
    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    // Pop: input holds the lock of its destination output and that output is ready.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 5; i++) begin
            for (int o = 0; o < 5; o++) begin
                if (reset && req[i] && (dst[i] == o[2:0]) && (state_q[o] == ST_BUSY) &&
                    (sel_q[o] == i[2:0]) && rdy[o]) begin
                    pop[i] = 1'b1;
                end
            end
        end
    end

    // Release: a tail flit popping through an output frees that output.
    always_comb begin
        rel = '0;
        for (int i = 0; i < 5; i++) begin
            for (int o = 0; o < 5; o++) begin
                if (pop[i] && tail[i] && (dst[i] == o[2:0])) begin
                    rel[o] = 1'b1;
                end
            end
        end
    end

    // Requests naming a non-existent output (codes 5..7).
    always_comb begin
        bad_dst = '0;
        for (int i = 0; i < 5; i++) begin
            bad_dst[i] = req[i] && (dst[i] > 3'd4);
        end
    end

    // Per-output next state: grant first candidate after the pointer, release on tail pop.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        win   = 3'd0;
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            ptr_d[o]   = ptr_q[o];
            found      = 1'b0;
            idx        = ptr_q[o];
            win        = 3'd0;
            if (state_q[o] == ST_IDLE) begin
                for (int k = 0; k < 5; k++) begin
                    idx = next_port(idx);
                    if (!found && req[idx] && (dst[idx] == o[2:0])) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found) begin
                    state_d[o] = ST_BUSY;
                    sel_d[o]   = win;
                end
            end else if (rel[o]) begin
                // Pointer moves only here, so the releasing source goes last next time.
                state_d[o] = ST_IDLE;
                sel_d[o]   = IDLE_CODE;
                ptr_d[o]   = sel_q[o];
            end
        end
    end

    // State, select and pointer registers; async reset drops every lock at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= ST_IDLE;
                sel_q[o]   <= IDLE_CODE;
                ptr_q[o]   <= RR_INIT;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            err_q <= |bad_dst;
        end
    end

    assign Ri      = sel_q[0];
    assign Le      = sel_q[1];
    assign Up      = sel_q[2];
    assign Do      = sel_q[3];
    assign Ej      = sel_q[4];
    assign R_pop   = pop[0];
    assign L_pop   = pop[1];
    assign U_pop   = pop[2];
    assign D_pop   = pop[3];
    assign EJ_pop  = pop[4];
    assign err_dst = err_q;

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output round-robin switch allocator for the 5-port router (R, L, U, D, EJ).
- Sits before the output-enable decode stage: takes each input's request (valid, destination, tail) and produces one registered 3-bit source-select code per output port, plus per-input pop grants.
- Holds a wormhole lock on each output from head grant until that packet's tail flit pops.
- Port code: 0=R, 1=L, 2=U, 3=D, 4=EJ, 7=idle (no source); 5 and 6 are illegal.

Parameters:
- IDLE_CODE, 3'b111, select value driven on an output with no granted source.
- RR_INIT, 3'd4, reset value of every round-robin pointer, so the first search order is R,L,U,D,EJ.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- R_req, L_req, U_req, D_req, EJ_req  input  1 each  input buffer holds a flit at its head.
- R_dst, L_dst, U_dst, D_dst, EJ_dst  input  3 each  destination output code of that head flit.
- R_tail, L_tail, U_tail, D_tail, EJ_tail  input  1 each  head flit is the packet tail; single-flit packets set tail on the head.
- R_rdy, L_rdy, U_rdy, D_rdy, EJ_rdy  input  1 each  output port can accept a flit this cycle.
- Ri, Le, Up, Do, Ej  output  3 each  registered source code granted to output R/L/U/D/EJ.
- R_pop, L_pop, U_pop, D_pop, EJ_pop  output  1 each  input flit is transferred this cycle (combinational).
- err_dst  output  1  registered one-cycle pulse when any requesting input presents code 5, 6 or 7.

Behaviour:
- Reset (reset=0, async):
  - All selects = IDLE_CODE, all locks clear, pointers = RR_INIT, err_dst = 0.
  - All pops = 0 while reset is asserted.
  - A reset mid-packet drops every lock immediately; no flit pops.
- State per output o:
  - sel_o (3b), lock_o (1b), ptr_o (3b).
  - Two states: IDLE (lock_o=0, sel_o=IDLE_CODE) and BUSY (lock_o=1, sel_o=source).
- IDLE -> BUSY:
  - Candidates are inputs i with req_i=1 and dst_i==o.
  - Search order starts at ptr_o+1 and wraps modulo 5 (4 -> 0).
  - First candidate wins. At the clock edge: sel_o <= i, lock_o <= 1.
  - Arbitration does not depend on rdy_o.
  - U-turns (dst equals own port) are legal.
- Pop (combinational):
  - pop_i = req_i & (dst_i in 0..4) & lock_dst_i & (sel_dst_i == i) & rdy_dst_i.
- BUSY -> IDLE: at the edge where pop_i=1 and tail_i=1 for the granted source i:
  - sel_o <= IDLE_CODE, lock_o <= 0, ptr_o <= i.
  - The pointer updates only on release, not on grant.
- BUSY, no tail pop:
  - Hold sel_o, even if req_i drops (bubble) or rdy_o=0 (backpressure).
- Latency:
  - Request at edge N is visible from cycle N; sel valid after edge N+1.
  - First pop occurs in cycle N+1 if rdy is high.
- Released output:
  - Spends at least one cycle in IDLE; no same-edge re-grant.
  - Back-to-back single-flit packets through one output therefore sustain 1 flit per 2 cycles.
- Illegal destination:
  - An input with dst 5, 6 or 7 is never a candidate and never pops.
  - err_dst <= 1 on the next edge for every cycle in which req_i=1 holds such a dst.
- Simultaneous events:
  - The five outputs arbitrate independently in the same cycle.
  - An input must keep dst constant from head to tail; a dst change while locked is a protocol violation, not checked.
- No combinational path from any req/dst to any select output. Selects are flops only.

Test Plan:
- Reset, then idle: all selects = 7, all pops = 0, err_dst = 0. Assert reset low mid-packet -> selects = 7 asynchronously, before the next edge.
- Single flit: L_req=1, L_dst=4, L_tail=1, EJ_rdy=1 at cycle 0 -> Ej=1 after edge 1, L_pop=1 in cycle 1, Ej=7 after edge 2.
- Contention: R, U and D all request output 1 (single-flit, always ready) from reset -> grant order R(0), U(2), D(3), then R again. Each packet takes 2 cycles; Le sequence is 0,7,2,7,3,7,0.
- Wormhole lock: U sends a 3-flit packet to D (tail on flit 3) while L requests D. Hold D_rdy=0 for 2 cycles mid-packet -> Do stays 2 throughout, U_pop=0 while not ready, L granted (Do=1) only after U's tail pop plus 1 idle cycle.
- Parallel: R->L, L->R, U->D, D->U, EJ->EJ all single-flit in the same cycle -> after one edge Ri=1, Le=0, Up=3, Do=2, Ej=4; all five pops = 1 in that cycle.
- Illegal destination: EJ_req=1, EJ_dst=6 for 3 cycles -> EJ_pop stays 0, Ej stays 7, err_dst=1 for 3 cycles lagging by one edge.
